// File: rtl/fp16_pkg.sv
// Shared FP16 definitions for the sequential subtractor and the round/pack stage.
// Field widths, special encodings, FSM states and the operand unpack helper.
package fp16_pkg;
  localparam int EXP_W  = 5;
  localparam int FRAC_W = 10;
  localparam int SIG_W  = 14;

  localparam logic [EXP_W-1:0] EXP_MAX = 5'd31;
  localparam logic [15:0]      QNAN    = 16'h7E00;
  localparam logic [15:0]      POS_INF = 16'h7C00;

  typedef enum logic [2:0] {
    S_IDLE,
    S_UNPACK,
    S_ALIGN,
    S_OP,
    S_NORM,
    S_ROUND,
    S_DONE
  } state_e;

  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] exp;
    logic [SIG_W-1:0] sig;
  } unp_t;

  // Subnormals get lead bit 0 and an effective exponent of 1.
  function automatic unp_t unpack(input logic [15:0] x);
    unp_t u;
    u.sign = x[15];
    u.exp  = (x[14:10] == '0) ? 5'd1 : x[14:10];
    u.sig  = {(|x[14:10]), x[FRAC_W-1:0], 3'b000};
    return u;
  endfunction
endpackage

// File: rtl/fp16_round_pack.sv
// Combinational round-to-nearest-even, carry renormalise, overflow detect and pack
// of a 15-bit extended significand (fres[14] = leading position).
module fp16_round_pack
  import fp16_pkg::*;
(
  input  logic           sign_i,
  input  logic [5:0]     exp_i,
  input  logic [SIG_W:0] fres_i,
  output logic [15:0]    res_o,
  output logic           ovf_o
);
  logic        rup;
  logic [11:0] mant;
  logic [10:0] mant_n;
  logic [5:0]  exp_n;

  always_comb begin
    // fres[4] is the LSB; fres[3] guard, fres[2:0] round/sticky.
    rup  = fres_i[3] & ((|fres_i[2:0]) | fres_i[4]);
    mant = {1'b0, fres_i[SIG_W:4]} + {11'b0, rup};
    if (mant[11]) begin
      mant_n = mant[11:1];
      exp_n  = exp_i + 6'd1;
    end else begin
      mant_n = mant[10:0];
      exp_n  = exp_i;
    end
    ovf_o = (exp_n >= {1'b0, EXP_MAX});
    // A cleared leading bit means the result stayed subnormal: exponent field 0.
    if (ovf_o) res_o = {sign_i, POS_INF[14:0]};
    else       res_o = {sign_i, (mant_n[10] ? exp_n[4:0] : 5'd0), mant_n[9:0]};
  end
endmodule

// File: rtl/fp16_sub_seq.sv
// Multi-cycle FP16 subtractor (res = a - b) with valid/ready on both sides.
// Define FP16_SUB_FAST_ALIGN_EN for single-cycle barrel align/normalise.
module fp16_sub_seq
  import fp16_pkg::*;
#(
  parameter int MAX_ALIGN = 14
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [15:0] res,
  output logic        V,
  output logic        out_valid,
  input  logic        out_ready,
  output state_e      dbg_state_o
);
  // Handshake: a transfer happens on any edge where valid & ready are both 1;
  // the producer holds its data stable while valid=1 and ready=0.
  state_e         state_q;
  logic [15:0]    a_q, b_q, res_q;
  logic           sign1_q, sign2_q, v_q, out_valid_q;
  logic [5:0]     exp_q;
  logic [SIG_W-1:0] op1_q, op2_q;
  logic [4:0]     d_q;
  logic [SIG_W:0] fres_q, fres_d;

  unp_t       ua, ub, u1, u2;
  logic       a_big, special;
  logic [4:0] ediff, d_d;
  logic [15:0] rp_res;
  logic        rp_ovf;

  function automatic logic need_norm(input logic [SIG_W:0] f, input logic [5:0] e);
    return !f[SIG_W] && (e > 6'd1);
  endfunction

  always_comb begin
    ua      = unpack(a_q);
    ub      = unpack(b_q);
    a_big   = (a_q[14:0] >= b_q[14:0]);
    u1      = a_big ? ua : ub;
    u2      = a_big ? ub : ua;
    ediff   = u1.exp - u2.exp;
    d_d     = (ediff > 5'(MAX_ALIGN)) ? 5'(MAX_ALIGN) : ediff;
    special = (a_q[14:10] == EXP_MAX) | (b_q[14:10] == EXP_MAX);
    fres_d  = (sign1_q != sign2_q) ? ({1'b0, op1_q} - {1'b0, op2_q})
                                   : ({1'b0, op1_q} + {1'b0, op2_q});
  end

`ifdef FP16_SUB_FAST_ALIGN_EN
  logic             byp_q, spec_q;
  logic [3:0]       lz;
  logic [5:0]       nsh, exp_bar;
  logic [SIG_W:0]   fres_bar;
  logic [SIG_W-1:0] op2_bar, lost_mask;

  always_comb begin
    lz = 4'd15;
    for (int i = 0; i <= SIG_W; i++) if (fres_q[i]) lz = 4'(SIG_W - i);
    nsh       = ({2'b0, lz} < (exp_q - 6'd1)) ? {2'b0, lz} : (exp_q - 6'd1);
    fres_bar  = fres_q << nsh;
    exp_bar   = exp_q - nsh;
    lost_mask = ~({SIG_W{1'b1}} << d_q);
    op2_bar   = (op2_q >> d_q) | {{(SIG_W-1){1'b0}}, |(op2_q & lost_mask)};
  end
`else
  logic [SIG_W-1:0] op2_step;
  logic [SIG_W:0]   fres_sh;

  always_comb begin
    // Bits shifted out stay sticky in bit 0.
    op2_step = {1'b0, op2_q[SIG_W-1:2], op2_q[1] | op2_q[0]};
    fres_sh  = {fres_q[SIG_W-1:0], 1'b0};
  end
`endif

  fp16_round_pack u_round_pack (
    .sign_i (sign1_q),
    .exp_i  (exp_q),
    .fres_i (fres_q),
    .res_o  (rp_res),
    .ovf_o  (rp_ovf)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      res_q       <= '0;
      v_q         <= 1'b0;
      out_valid_q <= 1'b0;
      sign1_q     <= 1'b0;
      sign2_q     <= 1'b0;
      exp_q       <= '0;
      op1_q       <= '0;
      op2_q       <= '0;
      d_q         <= '0;
      fres_q      <= '0;
`ifdef FP16_SUB_FAST_ALIGN_EN
      byp_q       <= 1'b0;
      spec_q      <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE: if (in_valid) begin
          a_q     <= a;
          b_q     <= {~b[15], b[14:0]};
          state_q <= S_UNPACK;
        end
        S_UNPACK: begin
          sign1_q <= u1.sign;
          sign2_q <= u2.sign;
          exp_q   <= {1'b0, u1.exp};
          op1_q   <= u1.sig;
          op2_q   <= u2.sig;
          d_q     <= d_d;
          if (special) begin
            res_q <= QNAN;
            v_q   <= 1'b1;
          end
`ifdef FP16_SUB_FAST_ALIGN_EN
          spec_q  <= special;
          state_q <= S_ALIGN;
`else
          if (special) begin
            out_valid_q <= 1'b1;
            state_q     <= S_DONE;
          end else begin
            state_q <= (d_d == '0) ? S_OP : S_ALIGN;
          end
`endif
        end
        S_ALIGN: begin
`ifdef FP16_SUB_FAST_ALIGN_EN
          op2_q   <= op2_bar;
          state_q <= spec_q ? S_NORM : S_OP;
`else
          op2_q <= op2_step;
          d_q   <= d_q - 5'd1;
          if (d_q == 5'd1) state_q <= S_OP;
`endif
        end
        S_OP: begin
          fres_q <= fres_d;
          exp_q  <= exp_q + 6'd1;
          if (fres_d == '0) begin
            res_q <= 16'h0000;
            v_q   <= 1'b0;
          end
`ifdef FP16_SUB_FAST_ALIGN_EN
          byp_q   <= (fres_d == '0);
          state_q <= S_NORM;
`else
          if (fres_d == '0) begin
            out_valid_q <= 1'b1;
            state_q     <= S_DONE;
          end else begin
            state_q <= need_norm(fres_d, exp_q + 6'd1) ? S_NORM : S_ROUND;
          end
`endif
        end
        S_NORM: begin
`ifdef FP16_SUB_FAST_ALIGN_EN
          fres_q <= fres_bar;
          exp_q  <= exp_bar;
          if (spec_q) begin
            out_valid_q <= 1'b1;
            state_q     <= S_DONE;
          end else begin
            state_q <= S_ROUND;
          end
`else
          fres_q  <= fres_sh;
          exp_q   <= exp_q - 6'd1;
          state_q <= need_norm(fres_sh, exp_q - 6'd1) ? S_NORM : S_ROUND;
`endif
        end
        S_ROUND: begin
`ifdef FP16_SUB_FAST_ALIGN_EN
          if (!byp_q) begin
            res_q <= rp_res;
            v_q   <= rp_ovf;
          end
`else
          res_q <= rp_res;
          v_q   <= rp_ovf;
`endif
          out_valid_q <= 1'b1;
          state_q     <= S_DONE;
        end
        S_DONE: if (out_ready) begin
          out_valid_q <= 1'b0;
          state_q     <= S_IDLE;
`ifdef FP16_SUB_FAST_ALIGN_EN
          byp_q       <= 1'b0;
          spec_q      <= 1'b0;
`endif
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign in_ready    = (state_q == S_IDLE);
  assign out_valid   = out_valid_q;
  assign res         = res_q;
  assign V           = v_q;
  assign dbg_state_o = state_q;
endmodule

// File: tb/tb_fp16_sub_seq.sv
// Scoreboard bench for fp16_sub_seq: directed vectors with hand-computed results,
// latency, output-stall stability and mid-operation reset.
module tb_fp16_sub_seq;
  import fp16_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] a = '0, b = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] res;
  logic        V;
  logic        out_valid;
  logic        out_ready = 1'b1;
  state_e      dbg_state;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // Scoreboard: {res, V} plus latency, stall length and accept cycle per item.
  logic [16:0] exp_q[$];
  int          lat_q[$];
  int          hold_q[$];
  int          acc_q[$];

  fp16_sub_seq #(.MAX_ALIGN(14)) dut (
    .clk         (clk),
    .rst         (rst),
    .a           (a),
    .b           (b),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .res         (res),
    .V           (V),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .dbg_state_o (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  // ---------------- driver ----------------
  // lat = 0 marks the zero-result shortcut, checked only against the 4+14 bound.
  task automatic send(input logic [15:0] va, input logic [15:0] vb,
                      input logic [15:0] vres, input logic vv, input int lat, input int hold);
    int k;
    @(negedge clk);
    a = va;
    b = vb;
    in_valid = 1'b1;
    k = 0;
    while (!in_ready && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (!in_ready) begin
      check("accept_timeout", 32'(in_ready), 32'd1);
    end else begin
      exp_q.push_back({vres, vv});
`ifdef FP16_SUB_FAST_ALIGN_EN
      lat_q.push_back((lat == 2) ? 4 : 6);
`else
      lat_q.push_back(lat);
`endif
      hold_q.push_back(hold);
      acc_q.push_back(cyc);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 300) begin
      @(negedge clk);
      k++;
    end
    check("drain_timeout", 32'(exp_q.size()), 32'd0);
    @(negedge clk);
  endtask

  // ---------------- monitor / scoreboard ----------------
  initial begin
    logic seen;
    int   hold_left;
    int   lat;
    seen = 1'b0;
    hold_left = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        seen = 1'b0;
      end else if (out_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_out_valid", 32'(out_valid), 32'd0);
          out_ready = 1'b1;
        end else begin
          if (!seen) begin
            seen = 1'b1;
            check("result", 32'({res, V}), 32'(exp_q[0]));
            lat = cyc - acc_q[0];
            if (lat_q[0] == 0) check("latency_bound", 32'(lat <= 18), 32'd1);
            else               check("latency", 32'(lat), 32'(lat_q[0]));
            hold_left = hold_q[0];
          end else begin
            check("stall_res", 32'({res, V}), 32'(exp_q[0]));
            check("stall_in_ready", 32'(in_ready), 32'd0);
          end
          if (hold_left > 0) begin
            out_ready = 1'b0;
            hold_left--;
          end else begin
            out_ready = 1'b1;
            void'(exp_q.pop_front());
            void'(lat_q.pop_front());
            void'(hold_q.pop_front());
            void'(acc_q.pop_front());
            seen = 1'b0;
          end
        end
      end else begin
        out_ready = 1'b1;
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("reset_in_ready", 32'(in_ready), 32'd1);
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_res", 32'(res), 32'h0000);
    check("reset_V", 32'(V), 32'd0);

    //    a        b        res      V     lat hold
    send(16'h3C00, 16'h3C00, 16'h0000, 1'b0, 0,  0);  // 1 - 1 = +0 shortcut
    send(16'h4000, 16'h3C00, 16'h3C00, 1'b0, 7,  0);  // 2 - 1
    send(16'h3C00, 16'h4000, 16'hBC00, 1'b0, 7,  0);  // 1 - 2
    send(16'h3C00, 16'h0001, 16'h3C00, 1'b0, 20, 0);  // d capped, sticky, round up
    send(16'h0400, 16'h0001, 16'h03FF, 1'b0, 5,  0);  // subnormal result
    send(16'h7C00, 16'h3C00, 16'h7E00, 1'b1, 2,  5);  // special, stalled output
    send(16'h3C00, 16'hBC00, 16'h4000, 1'b0, 4,  0);  // V must clear again
    send(16'h6400, 16'hB800, 16'h6400, 1'b0, 16, 0);  // tie, LSB even: stays
    send(16'h6401, 16'hB800, 16'h6402, 1'b0, 16, 0);  // tie, LSB odd: rounds up
    send(16'h0000, 16'h0000, 16'h0000, 1'b0, 0,  0);  // 0 - 0 = +0
    send(16'h7BFF, 16'hFBFF, 16'h7C00, 1'b1, 4,  0);  // overflow to +inf
    drain();

    // Reset while aligning: operation dropped, outputs back to reset values.
    @(negedge clk);
    a = 16'h3C00;
    b = 16'h0001;
    in_valid = 1'b1;
    check("rst_pre_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    check("rst_state_align", 32'(dbg_state), 32'(S_ALIGN));
    rst = 1'b1;
    @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_res", 32'(res), 32'h0000);
    check("rst_V", 32'(V), 32'd0);
    rst = 1'b0;

    send(16'h4000, 16'h3C00, 16'h3C00, 1'b0, 7, 0);
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/fp16_sub_seq.md
Name: fp16_sub_seq

Overview:
- Multi-cycle IEEE-754 half-precision subtractor: computes res = a − b.
- Companion to the combinational FP16 adder; runs on the same 16-bit format and the same 14-bit extended significand layout (hidden bit, 10 fraction bits, 3 guard/round/sticky bits).
- Replaces the combinational alignment and normalisation loops with one-bit-per-cycle shifting, with a valid/ready handshake on both sides.
- Feeds the datapath where an FP16 difference is needed without a long combinational path.

Parameters:
- MAX_ALIGN, 14, alignment shift cap in bits; larger exponent differences collapse entirely into the sticky bit.

Ports:
- clk  in  1  single clock; one clock; reset is synchronous and active-high
- rst  in  1  synchronous active-high reset
- a  in  16  minuend, {sign, exp[4:0], frac[9:0]}
- b  in  16  subtrahend, same format
- in_valid  in  1  operands valid
- in_ready  out  1  block can accept operands
- res  out  16  rounded difference
- V  out  1  overflow/invalid flag, qualified by out_valid
- out_valid  out  1  res/V valid
- out_ready  in  1  consumer accepts result

Behaviour:
- Reset: state=IDLE; in_ready=1; out_valid=0; res=16'h0000; V=0. Reset mid-operation aborts the operation; the operand is dropped with no output.
- Handshake:
  - Input transfer occurs when in_valid & in_ready; in_ready is 1 only in IDLE.
  - Output transfer occurs when out_valid & out_ready. res and V stay stable while out_valid=1 and out_ready=0.
- FSM states:
  - IDLE: on accept, capture a and b with b's sign inverted, go to UNPACK.
  - UNPACK (1 cycle):
    - Build significands {lead,frac,3'b0}; lead=0 when exp==0, and the effective exponent of a subnormal is 1.
    - Select the larger magnitude (exponent first, then fraction) as op1. d = |ea−eb|, capped at MAX_ALIGN.
    - Special case: if either exp==31, load res=16'h7E00, V=1, go to DONE.
  - ALIGN: shift op2 right one bit per cycle, OR each bit shifted out into op2[0], for d cycles (0 cycles when d=0); then go to OP.
  - OP (1 cycle):
    - 15-bit fres = op1 ± op2 (subtract if the effective signs differ); result exponent = larger exponent + 1; sign = sign of op1.
    - If fres==0, res=16'h0000 (+0), go to DONE.
  - NORM: while fres[14]==0 and exponent>1, shift fres left 1 and decrement the exponent, one step per cycle. A subnormal result exits with exponent field 0 when exponent==1 and fres[14]==0.
  - ROUND (1 cycle):
    - Round to nearest even on fres[3:0], with fres[4] as LSB and the tie broken to even.
    - A mantissa carry renormalises: shift right 1, exponent+1.
    - If the final exponent ≥ 31: res={sign,5'b11111,10'b0}, V=1; otherwise V=0.
  - DONE: out_valid=1; on out_ready go to IDLE with out_valid=0 in the next cycle.
- Latency from accept to out_valid = 4 + d + n cycles, with n = normalisation steps (n ≤ 14). Minimum is 4 cycles. Special operands reach DONE in 2 cycles.
- V is registered per result and never latches across operations.

Optional Feature:
- FP16_SUB_FAST_ALIGN_EN
- Defined: ALIGN and NORM become single-cycle barrel shifts, using a leading-zero count for NORM; sticky and round results are bit-identical. Latency is fixed at 6 cycles (4 for special operands).
- Undefined: iterative behaviour as above.

Decomposition:
- Package fp16_pkg:
  - Field widths: EXP_W=5, FRAC_W=10, SIG_W=14.
  - Constants: EXP_MAX=31, QNAN=16'h7E00, POS_INF=16'h7C00.
  - FSM state enum.
  - Unpacked-operand struct {sign, exp, sig}.
- Sub-module fp16_round_pack: combinational RNE rounding, carry renormalise, overflow detect and pack. The FP16 adder reuses it later.

Test Plan:
- 3C00 − 3C00 → res=0000, V=0, latency 4+0+14 normalisation steps bounded; result is +0 via the zero shortcut in OP.
- 4000 − 3C00 (2−1) → res=3C00, V=0; 3C00 − 4000 → res=BC00.
- 7BFF − FBFF (65504 − (−65504)) → res=7C00, V=1.
- 3C00 − 0001 → d capped at 14, sticky set, rounds to res=3C00, V=0; 0400 − 0001 → subnormal res=03FF.
- 7C00 − 3C00 → res=7E00, V=1 in 2 cycles.
- Hold out_ready=0 for 5 cycles after out_valid → res stable, in_ready=0; assert rst during ALIGN → next cycle out_valid=0, in_ready=1, res=0000.
